// File: rtl/timer_bank_pkg.sv
// timer_bank shared definitions: register map offsets, CTRL bits, byte lane helper.
package timer_bank_pkg;

    localparam logic [3:0] COUNT_OFS   = 4'd0;
    localparam logic [3:0] COMPARE_OFS = 4'd4;
    localparam logic [3:0] CTRL_OFS    = 4'd8;
    localparam int         CH_STRIDE   = 16;
    localparam logic [7:0] STATUS_ADDR = 8'hF0;
    localparam logic [7:0] PSRST_ADDR  = 8'hF1;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQEN  = 2;

    function automatic logic [7:0] byte_sel(
        input logic [31:0] v,
        input logic [1:0]  lane
    );
        logic [31:0] s;
        s = v >> {lane, 3'b000};
        return s[7:0];
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: COUNT/COMPARE/CTRL registers, tick step and CPU byte write port.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             we,
    input  logic [3:0]       ofs,
    input  logic [7:0]       din,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] compare,
    output logic [2:0]       ctrl,
    output logic             evt
);

    localparam int BYTES = WIDTH / 8;

    logic             cnt_hit;
    logic             cmp_hit;
    logic             ctrl_hit;
    logic             step;
    logic [1:0]       lane;
    logic [WIDTH-1:0] nxt;

    assign lane     = ofs[1:0];
    assign cnt_hit  = we && (ofs < COUNT_OFS + 4'(BYTES));
    assign cmp_hit  = we && (ofs >= COMPARE_OFS)
                         && (ofs < COMPARE_OFS + 4'(BYTES));
    assign ctrl_hit = we && (ofs == CTRL_OFS);

    // A CPU write to COUNT or CTRL owns the channel for this cycle.
    assign step = tick && ctrl[CTRL_EN] && !cnt_hit && !ctrl_hit;
    assign nxt  = count + WIDTH'(1);
    assign evt  = step && (nxt == compare);

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ctrl    <= '0;
        end else begin
            if (cnt_hit) begin
                for (int b = 0; b < BYTES; b++)
                    if (lane == 2'(b))
                        count[8*b +: 8] <= din;
            end else if (step) begin
                if (evt && ctrl[CTRL_RELOAD]) begin
                    count <= '0;
                end else begin
                    count <= nxt;
                    if (evt)
                        ctrl[CTRL_EN] <= 1'b0;
                end
            end

            if (cmp_hit) begin
                for (int b = 0; b < BYTES; b++)
                    if (lane == 2'(b))
                        compare[8*b +: 8] <= din;
            end

            if (ctrl_hit)
                ctrl <= din[2:0];
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped multi-channel timer bank: shared prescaler, STATUS, atomic
// COUNT snapshot, combinational read mux and Z80-style active-low interrupt.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 24000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic [7:0] addr,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       int_n,
    output logic       tick
);

    localparam int BYTES = WIDTH / 8;
    localparam int PW    = $clog2(PRESCALE);

    logic [3:0]          ch;
    logic [3:0]          ofs;
    logic                wr;
    logic                ch_valid;
    logic                psrst;
    logic                w1c;
    logic [PW-1:0]       pcnt;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] evt;
    logic [CHANNELS-1:0] ie;

    logic [WIDTH-1:0]    cnt [CHANNELS];
    logic [WIDTH-1:0]    cmp [CHANNELS];
    logic [2:0]          ctl [CHANNELS];

    logic [WIDTH-1:0]    sel_cnt;
    logic [WIDTH-1:0]    sel_cmp;
    logic [2:0]          sel_ctl;

    logic [WIDTH-1:0]    snap_val;
    logic [3:0]          snap_ch;
    logic                snap_vld;
    logic                snap_hit;
    logic                use_snap;

    logic                f_cnt;
    logic                f_cmp;
    logic                f_ctl;
    logic                f_stat;

    assign ch       = addr[7:4];
    assign ofs      = addr[3:0];
    assign wr       = cs && !wr_n;
    assign ch_valid = ch < 4'(CHANNELS);
    assign psrst    = wr && (addr == PSRST_ADDR);
    assign w1c      = wr && (addr == STATUS_ADDR);

    always_ff @(posedge clk) begin
        if (reset || psrst) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (pcnt == PW'(PRESCALE - 1));
            pcnt <= (pcnt == PW'(PRESCALE - 1)) ? '0 : pcnt + PW'(1);
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .we      (wr && (ch == 4'(n))),
            .ofs     (ofs),
            .din     (din),
            .count   (cnt[n]),
            .compare (cmp[n]),
            .ctrl    (ctl[n]),
            .evt     (evt[n])
        );
        assign ie[n] = ctl[n][CTRL_IRQEN];
    end

    // A channel event in the same cycle beats the W1C clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            int_n   <= 1'b1;
        end else begin
            pending <= (pending & ~(w1c ? din[CHANNELS-1:0] : '0)) | evt;
            int_n   <= ~|(pending & ie);
        end
    end

    always_comb begin
        sel_cnt = '0;
        sel_cmp = '0;
        sel_ctl = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == 4'(i)) begin
                sel_cnt = cnt[i];
                sel_cmp = cmp[i];
                sel_ctl = ctl[i];
            end
        end
    end

    assign snap_hit = cs && !rd_n && ch_valid && (ofs == COUNT_OFS);
    assign use_snap = snap_vld && (snap_ch == ch) && (ofs != COUNT_OFS);

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_val <= '0;
            snap_ch  <= '0;
            snap_vld <= 1'b0;
        end else if (snap_hit) begin
            snap_val <= sel_cnt;
            snap_ch  <= ch;
            snap_vld <= 1'b1;
        end
    end

    assign f_cnt  = ch_valid && (ofs < COUNT_OFS + 4'(BYTES));
    assign f_cmp  = ch_valid && (ofs >= COMPARE_OFS)
                             && (ofs < COMPARE_OFS + 4'(BYTES));
    assign f_ctl  = ch_valid && (ofs == CTRL_OFS);
    assign f_stat = (addr == STATUS_ADDR);

    always_comb begin
        dout = '0;
        if (cs) begin
            unique case (1'b1)
                f_cnt:   dout = use_snap ? byte_sel(32'(snap_val), ofs[1:0])
                                         : byte_sel(32'(sel_cnt), ofs[1:0]);
                f_cmp:   dout = byte_sel(32'(sel_cmp), ofs[1:0]);
                f_ctl:   dout = {5'b0, sel_ctl};
                f_stat:  dout = 8'(pending);
                default: dout = '0;
            endcase
        end
    end

endmodule
